// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Pipelined immediate-extension unit sitting between decode and execute.
//   Each item's immediate is extended combinationally and registered into
//   stage 1. It then moves through STAGES register stages under a
//   valid/ready handshake that has no bubbles. A sideband tag and the mode
//   travel with the data. acc_Count counts input handshakes since reset.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_Valid   upstream presents an item
//   in_Ready   unit accepts an item this cycle (does not depend on in_Valid)
//   in_Imm     raw immediate field (IN_W bits)
//   in_Mode    00 SEXT, 01 ZEXT, 10 LUI, 11 BOFF
//   in_Tag     sideband tag, passed through unchanged
//   out_Valid  output item valid
//   out_Ready  downstream accepts the output item
//   out_Ext    extended result (OUT_W bits)
//   out_Tag    tag belonging to out_Ext
//   out_Mode   mode belonging to out_Ext
//   acc_Count  input handshakes since reset, wraps modulo 2^CNT_W
module imm_extend_pipe #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_Valid,
  output logic             in_Ready,
  input  logic [IN_W-1:0]  in_Imm,
  input  logic [1:0]       in_Mode,
  input  logic [TAG_W-1:0] in_Tag,
  output logic             out_Valid,
  input  logic             out_Ready,
  output logic [OUT_W-1:0] out_Ext,
  output logic [TAG_W-1:0] out_Tag,
  output logic [1:0]       out_Mode,
  output logic [CNT_W-1:0] acc_Count
);

  localparam logic [1:0] MODE_SEXT = 2'b00;
  localparam logic [1:0] MODE_ZEXT = 2'b01;
  localparam logic [1:0] MODE_LUI  = 2'b10;
  localparam logic [1:0] MODE_BOFF = 2'b11;

  logic [OUT_W-1:0] sext_val;
  logic [OUT_W-1:0] zext_val;
  logic [OUT_W-1:0] lui_val;
  logic [OUT_W-1:0] boff_val;
  logic [OUT_W-1:0] ext_val;

  assign sext_val = {{(OUT_W-IN_W){in_Imm[IN_W-1]}}, in_Imm};
  assign zext_val = {{(OUT_W-IN_W){1'b0}}, in_Imm};
  assign lui_val  = {in_Imm, {(OUT_W-IN_W){1'b0}}};
  // Branch offset: the top two sign bits fall off, no saturation.
  assign boff_val = {sext_val[OUT_W-3:0], 2'b00};

  always_comb begin
    ext_val = sext_val;
    case (in_Mode)
      MODE_SEXT: ext_val = sext_val;
      MODE_ZEXT: ext_val = zext_val;
      MODE_LUI:  ext_val = lui_val;
      MODE_BOFF: ext_val = boff_val;
      default:   ext_val = sext_val;
    endcase
  end

  logic [STAGES-1:0]             valid_q;
  logic [STAGES-1:0][OUT_W-1:0]  data_q;
  logic [STAGES-1:0][TAG_W-1:0]  tag_q;
  logic [STAGES-1:0][1:0]        mode_q;
  logic [CNT_W-1:0]              acc_q;

  // space[k]: stage k can take a new item this cycle (empty or advancing).
  // go[k]:    stage k hands its item on (downstream or out of the unit).
  // load[k]:  stage k captures a new item.
  logic [STAGES-1:0]             space;
  logic [STAGES-1:0]             go;
  logic [STAGES-1:0]             load;
  logic [STAGES-1:0][OUT_W-1:0]  data_src;
  logic [STAGES-1:0][TAG_W-1:0]  tag_src;
  logic [STAGES-1:0][1:0]        mode_src;

  // The ready chain is flattened: stage k has room when the output drains
  // or any stage at or after k is empty. This keeps it free of
  // combinational self-reference and independent of in_Valid.
  for (genvar k = 0; k < STAGES; k++) begin : g_ctl
    assign space[k] = out_Ready || !(&valid_q[STAGES-1:k]);

    if (k == STAGES-1) begin : g_last
      assign go[k] = valid_q[k] && out_Ready;
    end else begin : g_mid
      assign go[k] = valid_q[k] && space[k+1];
    end

    if (k == 0) begin : g_first
      assign load[k]     = in_Valid && space[0];
      assign data_src[k] = ext_val;
      assign tag_src[k]  = in_Tag;
      assign mode_src[k] = in_Mode;
    end else begin : g_next
      assign load[k]     = go[k-1];
      assign data_src[k] = data_q[k-1];
      assign tag_src[k]  = tag_q[k-1];
      assign mode_src[k] = mode_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      tag_q   <= '0;
      mode_q  <= '0;
      acc_q   <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        // A stage that loads and empties in the same cycle keeps valid set.
        if (load[i]) begin
          valid_q[i] <= 1'b1;
          data_q[i]  <= data_src[i];
          tag_q[i]   <= tag_src[i];
          mode_q[i]  <= mode_src[i];
        end else if (go[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
      if (load[0]) begin
        acc_q <= acc_q + CNT_W'(1);
      end
    end
  end

  assign in_Ready  = space[0];
  assign out_Valid = valid_q[STAGES-1];
  assign out_Ext   = data_q[STAGES-1];
  assign out_Tag   = tag_q[STAGES-1];
  assign out_Mode  = mode_q[STAGES-1];
  assign acc_Count = acc_q;

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the pipelined MIPS datapath.
- Accepts an IN_W-bit immediate with a mode select and produces an OUT_W-bit operand. Supported modes: sign-extend, zero-extend, LUI upper placement, and branch offset (sign-extend then shift left by 2).
- Sits between decode and execute. Uses a valid/ready handshake with a STAGES-deep register pipeline, so stalls propagate without loss.
- A sideband tag (destination register) travels alongside the data. An accepted-transaction counter supports debug.

Parameters:
- IN_W, 16, immediate input width; legal when 2 <= IN_W <= OUT_W-2.
- OUT_W, 32, extended output width.
- STAGES, 2, number of pipeline register stages; legal range 1..4.
- TAG_W, 5, width of the sideband tag carried with each item.
- CNT_W, 16, width of the accepted-transaction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_Valid  input  1  upstream presents an item.
- in_Ready  output  1  unit accepts an item this cycle.
- in_Imm  input  IN_W  raw immediate field.
- in_Mode  input  2  extension mode: 00 = SEXT, 01 = ZEXT, 10 = LUI, 11 = BOFF.
- in_Tag  input  TAG_W  sideband tag, passed through unchanged.
- out_Valid  output  1  output item is valid.
- out_Ready  input  1  downstream accepts the output item.
- out_Ext  output  OUT_W  extended result.
- out_Tag  output  TAG_W  tag belonging to out_Ext.
- out_Mode  output  2  mode belonging to out_Ext.
- acc_Count  output  CNT_W  number of input handshakes since reset.

Behaviour:
- Reset: one or more cycles of rst high at a clk edge cause the following.
  - Every stage valid bit, out_Valid and acc_Count clear to 0.
  - out_Ext, out_Tag and out_Mode are 0.
  - in_Ready is 1 in the first cycle after rst deasserts.
  - If rst is asserted mid-operation, all in-flight items are discarded with no output handshake; rst overrides every other event in the same cycle.
- Handshakes:
  - An input handshake occurs when in_Valid and in_Ready are both 1 at a clk edge.
  - An output handshake occurs when out_Valid and out_Ready are both 1 at a clk edge.
  - While out_Valid is 1 and out_Ready is 0, out_Ext, out_Tag and out_Mode hold stable.
  - in_Ready must not depend combinationally on in_Valid.
- Extension function: computed combinationally ahead of stage 1 and registered into stage 1.
  - SEXT: in_Imm[IN_W-1] is replicated into bits OUT_W-1..IN_W.
  - ZEXT: bits OUT_W-1..IN_W are 0.
  - LUI: in_Imm is placed in bits OUT_W-1..OUT_W-IN_W; the low bits are 0.
  - BOFF: the SEXT result shifted left by 2; the top 2 bits are dropped (truncation, no saturation); bits 1..0 are 0.
- Pipeline:
  - Stage k holds valid_k, data_k, tag_k and mode_k. Stage STAGES drives the outputs.
  - Stage k advances when stage k+1 is empty or advancing. The last stage advances on an output handshake.
  - in_Ready = !valid_1 or stage 1 advancing; this is a ready chain with no bubbles.
  - Latency: an item accepted at edge N has out_Valid=1 after edge N+STAGES-1, so it is visible in the cycle following edge N+STAGES-1, provided out_Ready stayed 1.
  - Throughput is 1 item/cycle with out_Ready held at 1. Ordering is strictly FIFO.
  - Maximum occupancy is STAGES items. When full and out_Ready=0, in_Ready=0.
  - When full, an output handshake and an input handshake may occur in the same cycle; occupancy is unchanged.
- Counter:
  - acc_Count increments by 1 on each input handshake.
  - It wraps modulo 2^CNT_W.
  - It is cleared only by rst.

Test Plan:
- Modes, IN_W=16, OUT_W=32, STAGES=2, out_Ready=1. Expected out_Ext one per cycle, in order, two cycles after each accept:
  - in_Imm=0x8001 in SEXT -> 0xFFFF8001
  - 0x8001 in ZEXT -> 0x00008001
  - 0x1234 in LUI -> 0x12340000
  - 0xFFFF in BOFF -> 0xFFFFFFFC
  - 0x7FFF in BOFF -> 0x0001FFFC
- Backpressure: stream tags 1..6 with out_Ready held 0 for 5 cycles, then 1.
  - in_Ready drops after 2 accepts.
  - out_Ext/out_Tag hold stable throughout.
  - All 6 tags emerge in order with no duplicates or drops.
- Simultaneous events with the pipeline full: in the same cycle, out_Ready=1 and in_Valid=1.
  - One item is emitted and one is accepted.
  - in_Ready stays 1 on a continuous stream; no bubbles appear.
- Reset mid-operation: assert rst for 1 cycle with 2 items in flight.
  - out_Valid is 0 the next cycle and acc_Count=0.
  - Neither pre-reset item ever appears at the output.
- Counter wrap with CNT_W=4: perform 17 input handshakes -> acc_Count=1.
- Parameter sweep with STAGES=1 and STAGES=4, and with IN_W=8, OUT_W=16: 0x80 in SEXT -> 0xFF80, 0x80 in BOFF -> 0xFE00, with latency equal to STAGES.
